// File: rtl/job_request_packer.sv
// Purpose : packs nine 64-bit AXI4-Stream descriptor beats into one 576-bit job request beat; malformed frames are dropped and counted.
// Latency : m_job_tvalid rises 1 cycle after the beat carrying tlast.
// Backpr. : s_axis_tready drops only while a finished frame waits (HOLD) for the output register to free; m_job_tdata is stable while stalled.
//
// Ports:
//   aclk, aresetn           clock / asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast   64-bit descriptor input stream
//   m_job_tdata/tvalid/tready          576-bit assembled job request stream
//   drop_pulse              one-cycle pulse per discarded frame
//   drop_count              saturating count of discarded frames
//
// Optional build macro: JOB_PACKER_SANITY_CHECK_EN
//   When defined, complete frames with a bad image count (0 or > MAX_IMAGES),
//   zero width or zero height are dropped, unless job_ID is 0 (scratchpad config).

module job_request_packer #(
    parameter int DATA_W     = 64,
    parameter int NUM_BEATS  = 9,
    parameter int MAX_IMAGES = 5,
    parameter int CNT_W      = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [DATA_W*NUM_BEATS-1:0] m_job_tdata,
    output logic                        m_job_tvalid,
    input  logic                        m_job_tready,
    output logic                        drop_pulse,
    output logic [CNT_W-1:0]            drop_count
);

    localparam int OUT_W = DATA_W * NUM_BEATS;
    localparam int IDX_W = $clog2(NUM_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   beat_idx;
    logic [IDX_W-1:0]   beat_idx_nxt;
    logic [OUT_W-1:0]   asm_q;
    logic [OUT_W-1:0]   out_q;
    logic               out_vld;
    logic               rdy_q;
    logic               drop_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               last_slot;
    logic               out_take;
    logic [OUT_W-1:0]   frame;
    logic               bad_frame;
    logic               asm_wr;
    logic               load_direct;
    logic               load_hold;
    logic               drop_set;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign last_slot = (beat_idx == LAST_IDX);
    assign out_take  = out_vld && m_job_tready;

    // The complete frame as it looks while its final beat is on the bus.
    assign frame = {s_axis_tdata, asm_q[OUT_W-DATA_W-1:0]};

`ifdef JOB_PACKER_SANITY_CHECK_EN
    logic [15:0] f_width;
    logic [15:0] f_height;
    logic [7:0]  f_images;
    logic [7:0]  f_job_id;

    assign f_width  = frame[7*DATA_W +: 16];
    assign f_height = frame[7*DATA_W+16 +: 16];
    assign f_images = frame[7*DATA_W+32 +: 8];
    assign f_job_id = frame[8*DATA_W +: 8];

    // job_ID 0 is a scratchpad configuration frame whose beat 7 is not an image header.
    assign bad_frame = (f_job_id != 8'd0) &&
                       ((f_images == 8'd0) || (int'(f_images) > MAX_IMAGES) ||
                        (f_width == 16'd0) || (f_height == 16'd0));
`else
    assign bad_frame = 1'b0;
`endif

    // s_axis_tready is held low during reset by rdy_q and while HOLD owns asm.
    assign s_axis_tready = rdy_q && (state != HOLD);
    assign m_job_tdata   = out_q;
    assign m_job_tvalid  = out_vld;
    assign drop_pulse    = drop_q;
    assign drop_count    = cnt_q;

    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        asm_wr       = 1'b0;
        load_direct  = 1'b0;
        load_hold    = 1'b0;
        drop_set     = 1'b0;

        case (state)
            COLLECT: begin
                if (accept) begin
                    if (!last_slot) begin
                        if (s_axis_tlast) begin
                            drop_set     = 1'b1;
                            beat_idx_nxt = '0;
                        end else begin
                            asm_wr       = 1'b1;
                            beat_idx_nxt = beat_idx + 1'b1;
                        end
                    end else if (!s_axis_tlast) begin
                        // Too long: report once now, swallow the rest silently.
                        drop_set     = 1'b1;
                        beat_idx_nxt = '0;
                        state_nxt    = DISCARD;
                    end else if (bad_frame) begin
                        drop_set     = 1'b1;
                        beat_idx_nxt = '0;
                    end else if (!out_vld || out_take) begin
                        load_direct  = 1'b1;
                        beat_idx_nxt = '0;
                    end else begin
                        // Park the whole frame (including this beat) in asm.
                        asm_wr       = 1'b1;
                        beat_idx_nxt = '0;
                        state_nxt    = HOLD;
                    end
                end
            end
            DISCARD: begin
                if (accept && s_axis_tlast) begin
                    state_nxt = COLLECT;
                end
            end
            HOLD: begin
                if (out_take) begin
                    load_hold = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt    = COLLECT;
                beat_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= COLLECT;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            asm_q <= '0;
        end else if (asm_wr) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
                if (beat_idx == IDX_W'(k)) begin
                    asm_q[k*DATA_W +: DATA_W] <= s_axis_tdata;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else if (load_direct) begin
            out_q   <= frame;
            out_vld <= 1'b1;
        end else if (load_hold) begin
            out_q   <= asm_q;
            out_vld <= 1'b1;
        end else if (out_take) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q  <= 1'b0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rdy_q  <= 1'b1;
            drop_q <= drop_set;
            if (drop_set && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_job_request_packer.sv
module tb_job_request_packer;

    typedef logic [10:0][63:0] beats_t;

    typedef struct {
        string  name;
        beats_t b;
        int     nb;
        int     last_at;
        bit     exp_out;
        int     exp_pulses;
    } vec_t;

`ifdef JOB_PACKER_SANITY_CHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [63:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [575:0] m_job_tdata;
    logic         m_job_tvalid;
    logic         m_job_tready = 1'b1;
    logic         drop_pulse;
    logic [7:0]   drop_count;

    int tests = 0;
    int fails = 0;
    int timeouts = 0;
    int exp_cnt = 0;

    always #5 aclk = ~aclk;

    job_request_packer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_job_tdata   (m_job_tdata),
        .m_job_tvalid  (m_job_tvalid),
        .m_job_tready  (m_job_tready),
        .drop_pulse    (drop_pulse),
        .drop_count    (drop_count)
    );

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beats_t mk_job(input logic [63:0] base, input logic [15:0] w,
                                      input logic [15:0] h, input logic [7:0] cnt,
                                      input logic [7:0] job);
        beats_t b;
        b = '0;
        b[0] = base;
        for (int k = 1; k < 7; k++) b[k] = 64'(k) * 64'd1000000;
        b[7] = {24'h0, cnt, h, w};
        b[8] = {base[55:0], job};
        b[9] = 64'hDEAD_0000_0000_0009;
        b[10] = 64'hDEAD_0000_0000_000A;
        return b;
    endfunction

    // Drives one frame with tvalid held high; samples #1 after every edge.
    task automatic send_frame(input beats_t b, input int nb, input int last_at,
                              output int pulses, output int vlds,
                              output bit vld_after_last, output logic [575:0] cap);
        int n;
        pulses = 0;
        vlds = 0;
        vld_after_last = 1'b0;
        cap = '0;
        for (int i = 0; i < nb; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b[i];
            s_axis_tlast  = (i == last_at);
            n = 0;
            while (!s_axis_tready && n < 100) begin
                @(posedge aclk); #1;
                if (drop_pulse) pulses++;
                if (m_job_tvalid) begin vlds++; cap = m_job_tdata; end
                n++;
            end
            if (n >= 100) timeouts++;
            @(posedge aclk); #1;
            if (drop_pulse) pulses++;
            if (m_job_tvalid) begin vlds++; cap = m_job_tdata; end
            if (i == nb - 1) vld_after_last = m_job_tvalid;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge aclk); #1;
        if (drop_pulse) pulses++;
        if (m_job_tvalid) begin vlds++; cap = m_job_tdata; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];
    beats_t cfg, f1, f2, f3;
    int pulses, vlds;
    bit vla;
    logic [575:0] cap;

    initial begin
        cfg = {11{64'hFFFF_FFFF_FFFF_FFFF}};
        cfg[1] = 64'd300000000;
        cfg[2] = 64'd600000000;
        cfg[8] = 64'hFFFF_FFFF_FFFF_FF00;

        vecs[0] = '{"config",    cfg,                                         9, 8,  1'b1, 0};
        vecs[1] = '{"short",     mk_job(64'h1111, 16'd64, 16'd64, 8'd1, 8'd2), 6, 5,  1'b0, 1};
        vecs[2] = '{"good_a",    mk_job(64'h2222, 16'd640, 16'd480, 8'd1, 8'd2), 9, 8, 1'b1, 0};
        vecs[3] = '{"long",      mk_job(64'h3333, 16'd64, 16'd64, 8'd1, 8'd2), 11, 10, 1'b0, 1};
        vecs[4] = '{"good_max",  mk_job(64'h4444, 16'd32, 16'd16, 8'd5, 8'd5), 9, 8,  1'b1, 0};
        vecs[5] = '{"img7",      mk_job(64'h5555, 16'd1000, 16'd100, 8'd7, 8'd3), 9, 8, !SC, SC ? 1 : 0};
        vecs[6] = '{"width0",    mk_job(64'h6666, 16'd0, 16'd100, 8'd2, 8'd4), 9, 8, !SC, SC ? 1 : 0};
        vecs[7] = '{"exempt",    mk_job(64'h7777, 16'd5, 16'd0, 8'd0, 8'd0), 9, 8,  1'b1, 0};
        vecs[8] = '{"good_b",    mk_job(64'h8888, 16'd8, 16'd8, 8'd1, 8'd6), 9, 8,  1'b1, 0};

        // Reset state.
        #12;
        chk("rst_tready", 576'(s_axis_tready), 576'(0));
        chk("rst_tvalid", 576'(m_job_tvalid), 576'(0));
        chk("rst_tdata", m_job_tdata, 576'(0));
        chk("rst_pulse", 576'(drop_pulse), 576'(0));
        chk("rst_count", 576'(drop_count), 576'(0));
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rel_tready", 576'(s_axis_tready), 576'(1));

        // Frame table with downstream always ready.
        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].b, vecs[i].nb, vecs[i].last_at, pulses, vlds, vla, cap);
            exp_cnt += vecs[i].exp_pulses;
            chk({vecs[i].name, "_pulses"}, 576'(pulses), 576'(vecs[i].exp_pulses));
            chk({vecs[i].name, "_vld_cycles"}, 576'(vlds), 576'(vecs[i].exp_out ? 1 : 0));
            chk({vecs[i].name, "_latency"}, 576'(vla), 576'(vecs[i].exp_out));
            chk({vecs[i].name, "_count"}, 576'(drop_count), 576'(exp_cnt));
            if (vecs[i].exp_out) chk({vecs[i].name, "_data"}, cap, vecs[i].b[8:0]);
            if (i == 0) begin
                chk("cfg_beat1", 576'(cap[127:64]), 576'(64'd300000000));
                chk("cfg_beat2", 576'(cap[191:128]), 576'(64'd600000000));
                chk("cfg_jobid", 576'(cap[519:512]), 576'(0));
            end
        end
        chk("timeouts_table", 576'(timeouts), 576'(0));

        // Backpressure: first job held, second parked in HOLD.
        m_job_tready = 1'b0;
        f1 = mk_job(64'd10000000, 16'd1000, 16'd100, 8'd5, 8'd1);
        f2 = mk_job(64'h9999, 16'd800, 16'd600, 8'd3, 8'd7);
        send_frame(f1, 9, 8, pulses, vlds, vla, cap);
        chk("bp_f1_latency", 576'(vla), 576'(1));
        chk("bp_f1_data", cap, f1[8:0]);
        send_frame(f2, 9, 8, pulses, vlds, vla, cap);
        chk("bp_f2_pulses", 576'(pulses), 576'(0));
        for (int c = 0; c < 20; c++) begin
            chk("bp_hold_vld", 576'(m_job_tvalid), 576'(1));
            chk("bp_hold_data", m_job_tdata, f1[8:0]);
            chk("bp_hold_tready", 576'(s_axis_tready), 576'(0));
            @(posedge aclk); #1;
        end
        m_job_tready = 1'b1;
        @(posedge aclk); #1;
        chk("bp_f2_vld", 576'(m_job_tvalid), 576'(1));
        chk("bp_f2_data", m_job_tdata, f2[8:0]);
        chk("bp_tready_back", 576'(s_axis_tready), 576'(1));
        @(posedge aclk); #1;
        chk("bp_drained", 576'(m_job_tvalid), 576'(0));
        chk("bp_count", 576'(drop_count), 576'(exp_cnt));

        // Reset in the middle of a frame.
        f3 = mk_job(64'hAAAA, 16'd4, 16'd4, 8'd1, 8'd9);
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = f3[i];
            s_axis_tlast  = 1'b0;
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        #1 aresetn = 1'b0;
        #1;
        exp_cnt = 0;
        chk("mid_rst_vld", 576'(m_job_tvalid), 576'(0));
        chk("mid_rst_tready", 576'(s_axis_tready), 576'(0));
        chk("mid_rst_count", 576'(drop_count), 576'(0));
        chk("mid_rst_tdata", m_job_tdata, 576'(0));
        @(posedge aclk); @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("mid_rst_rel_tready", 576'(s_axis_tready), 576'(1));
        send_frame(f3, 9, 8, pulses, vlds, vla, cap);
        chk("post_rst_pulses", 576'(pulses), 576'(0));
        chk("post_rst_latency", 576'(vla), 576'(1));
        chk("post_rst_data", cap, f3[8:0]);
        chk("post_rst_count", 576'(drop_count), 576'(0));

        // Saturation: 300 back-to-back one-beat (short) frames.
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = 64'h1;
        repeat (300) @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("sat_pulse", 576'(drop_pulse), 576'(1));
        @(posedge aclk); #1;
        chk("sat_count", 576'(drop_count), 576'(255));
        chk("sat_pulse_end", 576'(drop_pulse), 576'(0));
        chk("sat_no_output", 576'(m_job_tvalid), 576'(0));
        chk("timeouts_all", 576'(timeouts), 576'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
